regs: RTL and testbench
=======================

REGS -- requirements
Module: regs

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH (32), SHALL set the width of each register and each data port.
REQ-002 Parameter RADDR_WIDTH, default `RADDR_WIDTH (5), SHALL set the width of each register address; depth SHALL be 2**RADDR_WIDTH (32).
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 we_i  input  1  SHALL be the write enable from the execute stage's reg_we_o.
REQ-006 waddr_i  input  RADDR_WIDTH  SHALL be the write address from the execute stage's reg_waddr_o.
REQ-007 wdata_i  input  DATA_WIDTH  SHALL be the write data from the execute stage's reg_wdata_o.
REQ-008 re1_i / re2_i  input  1 each  SHALL be the read enables for ports 1 and 2.
REQ-009 raddr1_i / raddr2_i  input  RADDR_WIDTH each  SHALL be the read addresses for ports 1 and 2.
REQ-010 rdata1_o / rdata2_o  output  DATA_WIDTH each  SHALL be the read data feeding the decode stage's op1/op2.
REQ-011 wr_count_o  output  32  SHALL be the count of accepted writes.

Function
REQ-012 Storage SHALL be 32 x DATA_WIDTH flip-flops; entry 0 (`ZERO_REG) SHALL always read `ZERO and SHALL never be written.
REQ-013 Write accepted SHALL mean rst_i=0, we_i=1 and waddr_i!=0 at a rising clk_i edge; the entry then SHALL hold wdata_i from the following cycle.
REQ-014 we_i=1 with waddr_i=0 SHALL change no state and SHALL NOT increment wr_count_o.
REQ-015 Reads SHALL be combinational, zero-cycle latency, both ports independent and usable in the same cycle.
REQ-016 Per port, in priority order: rst_i=1 -> `ZERO; re=0 -> `ZERO; raddr=0 -> `ZERO; bypass condition -> wdata_i; otherwise stored entry.
REQ-017 Bypass condition SHALL be we_i=1, waddr_i!=0 and waddr_i==raddr; the port SHALL then return the wdata_i being written in that cycle, not the old value.
REQ-018 Both ports addressing the write target in the same cycle SHALL both receive the bypassed wdata_i.
REQ-019 wr_count_o SHALL increment by 1 on each accepted write and SHALL wrap 0xFFFFFFFF -> 0x00000000 without flagging.
REQ-020 Back-to-back writes to one address SHALL keep the last value; each write SHALL count.
REQ-021 X on we_i while rst_i=0 SHALL be a usage error; no X tolerance is required.

Reset
REQ-022 At a rising edge with rst_i=1, all 32 entries SHALL clear to `ZERO and wr_count_o SHALL clear to 0.
REQ-023 rst_i=1 SHALL take priority over a simultaneous write; that write SHALL be discarded and SHALL NOT be counted.
REQ-024 While rst_i=1, rdata1_o and rdata2_o SHALL be `ZERO regardless of other inputs.
REQ-025 Reset asserted mid-sequence SHALL discard all prior contents; the first accepted write after rst_i falls SHALL set wr_count_o to 1.

Verification
REQ-026 Reset for 2 cycles, then read all 32 addresses on both ports with re=1 -> every read 0x00000000, wr_count_o=0.
REQ-027 Write x5=0xDEADBEEF, next cycle raddr1=5 with re1=1 -> rdata1_o=0xDEADBEEF, wr_count_o=1.
REQ-028 Write x0=0x12345678 with raddr1=raddr2=0 -> both ports 0 in that cycle and the next, wr_count_o unchanged.
REQ-029 x7 holds 0x1; same cycle write x7=0xA5A5A5A5 with raddr1=raddr2=7 -> both ports 0xA5A5A5A5 in that cycle; re2=0 instead -> rdata2_o=0.
REQ-030 Write x3=0x11 with rst_i=1 in that cycle, then read x3 after reset falls -> 0x00000000, wr_count_o=0.
REQ-031 Force wr_count_o to 0xFFFFFFFF (preload or 2**32 writes in a fast model), then one accepted write -> wr_count_o=0x00000000.

Source files
------------

// File: rtl/regs.sv
// Register file with 32 entries, two combinational read ports and one write port.
// Entry 0 is hardwired to zero. A read of the entry being written returns the new data.
module regs #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [RADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic                   re1_i,
  input  logic [RADDR_WIDTH-1:0] raddr1_i,
  input  logic                   re2_i,
  input  logic [RADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0]  rdata1_o,
  output logic [DATA_WIDTH-1:0]  rdata2_o,
  output logic [31:0]            wr_count_o
);

  localparam int unsigned Depth = 2 ** RADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [31:0]           wr_count_q;
  logic                  wr_accept;

  // Writes to entry 0 are dropped entirely, including the count.
  assign wr_accept = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wr_accept) begin
      mem_q[waddr_i] <= wdata_i;
      wr_count_q     <= wr_count_q + 32'd1;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic                   re,
                                                      input logic [RADDR_WIDTH-1:0] raddr);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    if (rst_i || !re || (raddr == '0)) begin
      data = '0;
    end else if (wr_accept && (waddr_i == raddr)) begin
      data = wdata_i;
    end else begin
      data = mem_q[raddr];
    end
    return data;
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i);
    rdata2_o = read_port(re2_i, raddr2_i);
  end

  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_regs.sv
// Bench for regs: directed scenarios then random traffic, checked against an
// array-based model of the register file and a write counter.
module tb_regs;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] wr_count;

  int tests;
  int failed;

  logic [31:0] model_mem [32];
  logic [31:0] model_count;

  regs #(
    .DATA_WIDTH (32),
    .RADDR_WIDTH(5)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .re1_i     (re1),
    .raddr1_i  (raddr1),
    .re2_i     (re2),
    .raddr2_i  (raddr2),
    .rdata1_o  (rdata1),
    .rdata2_o  (rdata2),
    .wr_count_o(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read port must show this cycle, from the current model and driven inputs.
  function automatic logic [31:0] expect_read(input logic r_en, input logic [4:0] ra);
    if (rst) return 32'h0;
    if (!r_en || ra == 5'd0) return 32'h0;
    if (we && waddr != 5'd0 && waddr == ra) return wdata;
    return model_mem[ra];
  endfunction

  // Drive one cycle, check both read ports before the edge and the count after it.
  task automatic step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    check({tag, ".rd1"}, rdata1, expect_read(re1, raddr1));
    check({tag, ".rd2"}, rdata2, expect_read(re2, raddr2));
    if (r) begin
      foreach (model_mem[i]) model_mem[i] = 32'h0;
      model_count = 32'h0;
    end else if (w && wa != 5'd0) begin
      model_mem[wa] = wd;
      model_count   = model_count + 32'd1;
    end
    @(posedge clk);
    #1;
    check({tag, ".cnt"}, wr_count, model_count);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    foreach (model_mem[i]) model_mem[i] = 32'h0;
    model_count = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    // Two reset cycles with junk on the other inputs; reads must stay zero.
    step("rst0", 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 5'd9, 1'b1, 5'd9);
    step("rst1", 1'b1, 1'b1, 5'd4, 32'h1234_5678, 1'b1, 5'd4, 1'b1, 5'd1);

    for (int a = 0; a < 32; a++) begin
      step("rdall", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
    end

    step("wr5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd5", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("rd5.abs", rdata1, 32'hDEAD_BEEF);
    check("wr5.cnt_abs", wr_count, 32'd1);

    step("wr0", 1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0);
    step("wr0.next", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);

    step("wr7a", 1'b0, 1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 1'b1, 5'd7);
    step("byp7", 1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
    step("byp7.re2off", 1'b0, 1'b1, 5'd7, 32'h5A5A_5A5A, 1'b1, 5'd7, 1'b0, 5'd7);
    step("rd7", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);

    // Reset wins over a same-cycle write and clears the count.
    step("rstwr3", 1'b1, 1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3, 1'b1, 5'd3);
    step("rd3", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7);
    check("rd3.cnt_abs", wr_count, 32'd0);
    step("firstwr", 1'b0, 1'b1, 5'd12, 32'h0BAD_CAFE, 1'b1, 5'd12, 1'b0, 5'd0);
    check("firstwr.cnt_abs", wr_count, 32'd1);

    // Random traffic over a narrow address window to provoke bypasses and overwrites.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      r  = ($urandom_range(0, 39) == 0);
      wa = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      step("rand", r, 1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0), a1,
           1'($urandom_range(0, 3) != 0), a2);
    end

    // Preload the counter just below wrap.
    @(negedge clk);
    dut.wr_count_q = 32'hFFFF_FFFF;
    model_count    = 32'hFFFF_FFFF;
    step("wrap.x0", 1'b0, 1'b1, 5'd0, 32'h7777_7777, 1'b1, 5'd1, 1'b1, 5'd2);
    check("wrap.hold_abs", wr_count, 32'hFFFF_FFFF);
    step("wrap", 1'b0, 1'b1, 5'd9, 32'h9999_9999, 1'b1, 5'd9, 1'b1, 5'd9);
    check("wrap.cnt_abs", wr_count, 32'h0000_0000);
    step("wrap.after", 1'b0, 1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd9, 1'b0, 5'd9);
    check("wrap.after_abs", wr_count, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
